// File: rtl/dm_uart_tx.sv
// dm_uart_tx: bus-mapped UART transmitter with a small TX FIFO.
// Registers (addr[3:2]): 0 = TXDATA (write only), 1 = STATUS.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
module dm_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        inclk,
  input  logic        rst,
  input  logic        CS,
  input  logic        R,
  input  logic        W,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] DivMax = 16'(CLK_DIV - 1);
  localparam logic [3:0]  DepthC = 4'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cyc_q, cyc_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic        wr_txdata, wr_status, rd_status;
  logic        fifo_empty, fifo_full;
  logic        bit_end, pop, push_ok;
  logic [7:0]  head;
  logic [31:0] status;
  logic        unused_bits;

  assign wr_txdata  = CS & W & (addr[3:2] == 2'd0);
  assign wr_status  = CS & W & (addr[3:2] == 2'd1);
  assign rd_status  = CS & R & (addr[3:2] == 2'd1);
  assign fifo_empty = (count_q == 4'd0);
  assign fifo_full  = (count_q == DepthC);
  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (cyc_q == DivMax);
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign push_ok    = wr_txdata & (~fifo_full | pop);
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:8]};

  // State register
  always_ff @(posedge inclk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: counters, shifter, FIFO control, tx line
  always_ff @(posedge inclk) begin
    if (rst) begin
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge inclk) begin
    mem_q <= mem_d;
  end

  // Next-state logic: frame sequencing, bit/cycle counters, head pop
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StStart;
          cyc_d   = '0;
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          cyc_d = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!fifo_empty) begin
            state_d = StStart;
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = StIdle;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata[7:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 4'd1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 4'd1;
    end
    if (wr_status && wdata[3]) begin
      ovf_d = 1'b0;
    end
    // A dropped push beats a simultaneous clear.
    if (wr_txdata && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // Outputs: registered tx level for the upcoming state, combinational STATUS read
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = par_d;
`endif
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    status = {24'd0, count_q, ovf_q, fifo_empty, fifo_full, (state_q != StIdle)};
    rdata  = rd_status ? status : 32'd0;
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_dm_uart_tx.sv
// Directed self-checking bench for dm_uart_tx at CLK_DIV=4, FIFO_DEPTH=8.
module tb_dm_uart_tx;

  localparam int Div = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int FrameCyc = Div * FrameBits;

  logic        inclk = 1'b0;
  logic        rst   = 1'b0;
  logic        CS    = 1'b0;
  logic        R     = 1'b0;
  logic        W     = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;

  int total_cnt = 0;
  int pass_cnt  = 0;

  dm_uart_tx #(
    .CLK_DIV   (Div),
    .FIFO_DEPTH(8)
  ) dut (
    .inclk(inclk),
    .rst  (rst),
    .CS   (CS),
    .R    (R),
    .W    (W),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .tx   (tx)
  );

  always #5 inclk = ~inclk;

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    CS = 1'b1; W = 1'b1; addr = a; wdata = d;
    tick();
    CS = 1'b0; W = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic read_status(output logic [31:0] v);
    CS = 1'b1; R = 1'b1; addr = 32'h4;
    #1;
    v = rdata;
    CS = 1'b0; R = 1'b0; addr = '0;
  endtask

  // Expected line level at cycle i of a frame carrying byte b.
  function automatic logic exp_tx(input logic [7:0] b, input int i);
    int k;
    k = i / Div;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks frame cycles first..FrameCyc-1, one tick per cycle.
  task automatic expect_frame(input string tag, input logic [7:0] b, input int first);
    logic [31:0] st;
    for (int i = first; i < FrameCyc; i++) begin
      tick();
      check({tag, "_tx"}, {31'd0, tx}, {31'd0, exp_tx(b, i)});
      read_status(st);
      check({tag, "_busy"}, {31'd0, st[0]}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] st;
    int lows;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    read_status(st);
    check("reset_status", st, 32'h4);
    check("reset_tx", {31'd0, tx}, 32'd1);

    // Single frame 0x55; push edge leaves tx high, frame starts on the next edge
    bus_write(32'h0, 32'h55);
    check("push_tx_idle", {31'd0, tx}, 32'd1);
    read_status(st);
    check("push_status", st, 32'h10);
    expect_frame("f55", 8'h55, 0);
    tick();
    read_status(st);
    check("f55_done_status", st, 32'h4);
    check("f55_done_tx", {31'd0, tx}, 32'd1);

    // Nine consecutive writes from idle: pop on the second edge keeps all nine
    CS = 1'b1; W = 1'b1; addr = 32'h0;
    for (int j = 1; j <= 9; j++) begin
      wdata = j;
      tick();
    end
    CS = 1'b0; W = 1'b0; wdata = '0;
    read_status(st);
    check("burst9_status", st, 32'h83);

    // Drain everything
    for (int n = 0; n < 1000; n++) begin
      read_status(st);
      if (st == 32'h4) break;
      tick();
    end
    read_status(st);
    check("drain_status", st, 32'h4);

    // Back-to-back frames: no idle-high gap between stop and next start
    bus_write(32'h0, 32'hA1);
    CS = 1'b1; W = 1'b1; addr = 32'h0; wdata = 32'h3C;
    tick();
    CS = 1'b0; W = 1'b0; wdata = '0;
    check("b2b_first_start", {31'd0, tx}, 32'd0);
    expect_frame("fA1", 8'hA1, 1);
    expect_frame("f3C", 8'h3C, 0);
    tick();
    read_status(st);
    check("b2b_done_status", st, 32'h4);

    // Overflow while busy: 8 of 9 accepted, 9th dropped
    bus_write(32'h0, 32'h11);
    tick();
    CS = 1'b1; W = 1'b1; addr = 32'h0;
    for (int j = 1; j <= 9; j++) begin
      wdata = 32'h20 + j;
      tick();
    end
    CS = 1'b0; W = 1'b0; wdata = '0;
    read_status(st);
    check("ovf_status", st, 32'h8B);

    // Write+read of STATUS together: read sees overflow, write clears it
    CS = 1'b1; W = 1'b1; R = 1'b1; addr = 32'h4; wdata = 32'h8;
    #1;
    check("rw_read", rdata, 32'h8B);
    tick();
    CS = 1'b0; W = 1'b0; R = 1'b0; addr = '0; wdata = '0;
    read_status(st);
    check("ovf_clear", st, 32'h83);

    // Unmapped write ignored; reads of other offsets return 0
    bus_write(32'h8, 32'hFF);
    read_status(st);
    check("unmapped_write", st, 32'h83);
    CS = 1'b1; R = 1'b1; addr = 32'h0;
    #1;
    check("read_txdata_zero", rdata, 32'h0);
    CS = 1'b0; R = 1'b0;

    // Reset mid-DATA with bytes queued and a simultaneous write that must be lost
    rst = 1'b1; CS = 1'b1; W = 1'b1; addr = 32'h0; wdata = 32'h77;
    tick();
    rst = 1'b0; CS = 1'b0; W = 1'b0; wdata = '0;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    read_status(st);
    check("midrst_status", st, 32'h4);
    lows = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("midrst_no_frame", lows, 32'd0);
    read_status(st);
    check("midrst_status_late", st, 32'h4);

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0x07 has odd weight -> parity 1; 0x03 -> parity 0
    bus_write(32'h0, 32'h07);
    expect_frame("p07", 8'h07, 0);
    tick();
    read_status(st);
    check("p07_done", st, 32'h4);
    bus_write(32'h0, 32'h03);
    expect_frame("p03", 8'h03, 0);
    tick();
    read_status(st);
    check("p03_done", st, 32'h4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dm_uart_tx.md
DM_UART_TX -- requirements
Module: dm_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: inclk cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries, power of two, legal range 2..8.
REQ-003 SHALL have port inclk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port CS  input  1  peripheral select from the CPU data bus, decoded externally.
REQ-006 SHALL have port R  input  1  bus read strobe.
REQ-007 SHALL have port W  input  1  bus write strobe.
REQ-008 SHALL have port addr  input  32  byte address; only addr[3:2] is decoded.
REQ-009 SHALL have port wdata  input  32  bus write data.
REQ-010 SHALL have port rdata  output  32  bus read data.
REQ-011 SHALL have port tx  output  1  serial line; idle level is high.

Function
REQ-012 Register map (addr[3:2]) SHALL be: 0 = TXDATA (write only), 1 = STATUS, 2 and 3 = unmapped.
REQ-013 rdata SHALL be combinational; it SHALL equal STATUS when CS&R&(addr[3:2]==1), else 0.
REQ-014 STATUS SHALL be: [0] busy (state!=IDLE), [1] full, [2] empty, [3] overflow (sticky), [7:4] count, [31:8] 0.
REQ-015 A CS&W write to TXDATA at an edge SHALL push wdata[7:0] into the FIFO.
REQ-016 A push when the FIFO is full SHALL be dropped and SHALL set overflow.
  - Exception: if a pop occurs in the same cycle, the push is accepted.
REQ-017 A CS&W write to STATUS with wdata[3]=1 SHALL clear overflow.
  - If a dropped push occurs in the same cycle, the set wins.
REQ-018 Writes to unmapped offsets SHALL be ignored; W and R both asserted SHALL act as a write plus a read.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY (only with the macro), and STOP.
REQ-020 IDLE SHALL move to START at the first edge at which the FIFO is non-empty; that edge SHALL pop the head byte into the shift register.
REQ-021 Each non-IDLE state SHALL hold its tx level for exactly CLK_DIV cycles using a bit counter.
  - START drives 0.
  - DATA drives 8 bits, LSB first.
  - STOP drives 1.
REQ-022 At the end of STOP, the FSM SHALL go to START (popping the FIFO) if the FIFO is non-empty, else to IDLE.
  - Result: back-to-back frames with no idle gap.
REQ-023 Latency SHALL be: a TXDATA write at edge k into an empty FIFO with FSM IDLE gives tx=0 after edge k+1.
REQ-024 tx SHALL be driven from a register (glitch-free).
REQ-025 count SHALL be 0..FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 When rst=1 at an edge, the block SHALL reset as follows, with no partial frame resumed:
  - FSM goes to IDLE.
  - FIFO is emptied (count=0).
  - overflow is cleared.
  - Bit and cycle counters are zeroed.
  - tx=1.
REQ-027 Reset SHALL take priority over any simultaneous bus write, and that write SHALL be lost.
REQ-028 After reset, STATUS SHALL read 0x00000004.

Configuration
REQ-029 Macro UART_TX_PARITY_EN SHALL control the parity bit.
  - Defined: PARITY state between DATA and STOP drives even parity (XOR of the 8 data bits) for CLK_DIV cycles; frame = 11 bits.
  - Undefined: no PARITY state; frame = 10 bits.

Verification
REQ-030 CLK_DIV=4, write 0x55 to TXDATA -> after the next edge tx=0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles; busy=1 for 40 cycles, then STATUS=0x04.
REQ-031 FSM IDLE, 9 writes on consecutive cycles (0x01..0x09), FIFO_DEPTH=8 -> first byte popped at the 2nd edge, all 9 writes accepted, overflow=0.
  - Repeat while FSM busy with 9 pushes -> 9th dropped, overflow=1, count=8.
  - Then write STATUS wdata=0x8 -> overflow=0.
REQ-032 Two queued bytes -> the second start bit begins the cycle after the first stop bit's 4th cycle, with no idle-high gap.
REQ-033 rst=1 mid-DATA with 3 bytes queued -> next cycle tx=1, STATUS=0x04; no further frame emitted.
REQ-034 UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 after the 8 data bits; write 0x03 -> parity bit 0; frame lasts 44 cycles at CLK_DIV=4.
